// File: rtl/shift_scheduler.sv
// Two-requester round-robin shift unit.
// Shifts one bit per cycle; result held until the consumer takes it.
module shift_scheduler #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHW-1:0]   req1_shamt,
    input  logic [1:0]       req1_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [SHW-1:0] ONE = SHW'(1);

    state_t           state;
    logic             ptr;
    logic             id_r;
    logic [1:0]       op_r;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] work;

    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] g_data;
    logic [SHW-1:0]   g_shamt;
    logic [1:0]       g_op;
    logic [WIDTH-1:0] shifted;

    // ptr == 0 favours requester 0 when both are asking
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state == IDLE) begin
            gnt0 = req0_valid && (!req1_valid || !ptr);
            gnt1 = req1_valid && (!req0_valid || ptr);
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign g_data     = gnt1 ? req1_data  : req0_data;
    assign g_shamt    = gnt1 ? req1_shamt : req0_shamt;
    assign g_op       = gnt1 ? req1_op    : req0_op;

    always_comb begin
        shifted = work;
        unique case (op_r)
            2'b00:   shifted = {work[WIDTH-2:0], 1'b0};
            2'b01:   shifted = {1'b0, work[WIDTH-1:1]};
            2'b10:   shifted = {work[WIDTH-1], work[WIDTH-1:1]};
            default: shifted = work;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            id_r     <= 1'b0;
            op_r     <= 2'b00;
            cnt      <= '0;
            work     <= '0;
            out_data <= '0;
            out_id   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        id_r <= gnt1;
                        op_r <= g_op;
                        cnt  <= g_shamt;
                        work <= g_data;
                        if (g_shamt == '0 || g_op == 2'b11) begin
                            state    <= DONE;
                            out_data <= g_data;
                            out_id   <= gnt1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt - ONE;
                    if (cnt == ONE) begin
                        state    <= DONE;
                        out_data <= shifted;
                        out_id   <= id_r;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        ptr   <= ~id_r;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_shift_scheduler.sv
// Bench for shift_scheduler: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_shift_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_op, req1_op;
    logic        out_valid, out_ready, out_id, busy;
    logic [31:0] out_data;

    int errors = 0;
    int checks = 0;

    shift_scheduler #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data(req0_data), .req0_shamt(req0_shamt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data(req1_data), .req1_shamt(req1_shamt), .req1_op(req1_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(logic [31:0] d, int s, logic [1:0] op);
        logic signed [31:0] sd;
        sd = d;
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return sd >>> s;
            default: return d;
        endcase
    endfunction

    function automatic int ref_lat(int s, logic [1:0] op);
        return (op == 2'b11 || s == 0) ? 1 : 1 + s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_data = 0; req0_shamt = 0; req0_op = 0;
        req1_valid = 0; req1_data = 0; req1_shamt = 0; req1_op = 0;
        out_ready  = 1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1;
    endtask

    // Counts edges from the accepting edge to the first out_valid window.
    task automatic wait_out(output int n);
        n = -1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 1) begin
                req0_valid = 0;
                req1_valid = 0;
            end
            if (out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        req0_valid = 1;
        req1_valid = 1;
        tick();
        tick();
        #1;
        checks++;
        if ({out_valid, out_id, busy, req0_ready, req1_ready} !== 5'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset: ov=%b id=%b busy=%b r0=%b r1=%b data=%h, want all 0",
                     out_valid, out_id, busy, req0_ready, req1_ready, out_data);
        end
        idle_inputs();
        rst_n = 1;
        tick();
    endtask

    task automatic test_sra();
        int n;
        do_reset();
        req0_valid = 1; req0_data = 32'h8000_0000; req0_shamt = 31; req0_op = 2'b10;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL sra_ready: got %b want 1", req0_ready);
        end
        wait_out(n);
        checks++;
        if (n != 32 || out_data !== 32'hFFFF_FFFF || out_id !== 1'b0) begin
            errors++;
            $display("FAIL sra: lat=%0d data=%h id=%b want lat=32 data=ffffffff id=0", n, out_data, out_id);
        end
        tick();
    endtask

    task automatic test_sll_srl();
        int n;
        do_reset();
        req1_valid = 1; req1_data = 32'h1; req1_shamt = 4; req1_op = 2'b00;
        wait_out(n);
        checks++;
        if (n != 5 || out_data !== 32'h10 || out_id !== 1'b1) begin
            errors++;
            $display("FAIL sll: lat=%0d data=%h id=%b want lat=5 data=00000010 id=1", n, out_data, out_id);
        end
        tick();
        req1_valid = 1; req1_data = 32'hF000_0000; req1_shamt = 28; req1_op = 2'b01;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL srl_ready: got %b want 1 (no bubble)", req1_ready);
        end
        wait_out(n);
        checks++;
        if (n != 29 || out_data !== 32'hF || out_id !== 1'b1) begin
            errors++;
            $display("FAIL srl: lat=%0d data=%h id=%b want lat=29 data=0000000f id=1", n, out_data, out_id);
        end
        tick();
    endtask

    task automatic test_alternate();
        int g;
        int exp_g[3] = '{0, 1, 0};
        do_reset();
        req0_valid = 1; req0_data = 32'hA; req0_shamt = 3; req0_op = 2'b00;
        req1_valid = 1; req1_data = 32'hB; req1_shamt = 2; req1_op = 2'b01;
        for (int k = 0; k < 3; k++) begin
            g = -1;
            for (int i = 0; i < 64; i++) begin
                #1;
                if (req0_ready && req1_ready) g = 2;
                else if (req0_ready) g = 0;
                else if (req1_ready) g = 1;
                if (g >= 0) break;
                tick();
            end
            checks++;
            if (g != exp_g[k]) begin
                errors++;
                $display("FAIL alternate[%0d]: granted %0d want %0d", k, g, exp_g[k]);
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_pass();
        int n;
        do_reset();
        req0_valid = 1; req0_data = 32'h1234_5678; req0_shamt = 7; req0_op = 2'b11;
        wait_out(n);
        checks++;
        if (n != 1 || out_data !== 32'h1234_5678 || out_id !== 1'b0) begin
            errors++;
            $display("FAIL pass: lat=%0d data=%h id=%b want lat=1 data=12345678 id=0", n, out_data, out_id);
        end
        tick();
    endtask

    task automatic test_hold();
        logic [31:0] d;
        int n;
        do_reset();
        d = $urandom;
        out_ready = 0;
        req0_valid = 1; req0_data = d; req0_shamt = 2; req0_op = 2'b00;
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_data = 32'h0000_0F00; req1_shamt = 8; req1_op = 2'b01;
        n = -1;
        for (int i = 0; i < 16; i++) begin
            if (out_valid) begin n = i; break; end
            tick();
        end
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL hold_timeout: out_valid never rose, want 1");
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== (d << 2) || out_id !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: ov=%b data=%h id=%b r0=%b r1=%b want 1 %h 0 0 0",
                         i, out_valid, out_data, out_id, req0_ready, req1_ready, d << 2);
            end
            tick();
        end
        out_ready = 1;
        #1;
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_early_accept: r1=%b want 0", req1_ready);
        end
        tick();
        checks++;
        if (req1_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_accept: r1=%b ov=%b want 1 0", req1_ready, out_valid);
        end
        wait_out(n);
        checks++;
        if (n != 9 || out_data !== 32'hF || out_id !== 1'b1) begin
            errors++;
            $display("FAIL hold_next: lat=%0d data=%h id=%b want 9 0000000f 1", n, out_data, out_id);
        end
        tick();
    endtask

    task automatic test_midreset();
        int n;
        do_reset();
        req0_valid = 1; req0_data = 32'h3; req0_shamt = 1; req0_op = 2'b00;
        wait_out(n);
        tick();
        req1_valid = 1; req1_data = 32'hFF; req1_shamt = 20; req1_op = 2'b00;
        tick();
        req1_valid = 0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_shift: busy=%b ov=%b want 1 0", busy, out_valid);
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: busy=%b ov=%b want 0 0", busy, out_valid);
        end
        req0_valid = 1; req0_data = 32'h5; req0_shamt = 0; req0_op = 2'b01;
        req1_valid = 1; req1_data = 32'h6; req1_shamt = 0; req1_op = 2'b01;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_grant: r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        wait_out(n);
        checks++;
        if (n != 1 || out_data !== 32'h5 || out_id !== 1'b0) begin
            errors++;
            $display("FAIL midreset_result: lat=%0d data=%h id=%b want 1 00000005 0", n, out_data, out_id);
        end
        tick();
    endtask

    task automatic test_random();
        bit          v[2];
        logic [31:0] d[2];
        int          s[2];
        logic [1:0]  o[2];
        bit          m_idle = 1;
        bit          m_ptr = 0;
        bit          m_id = 0;
        logic [31:0] m_exp = 0;
        int          m_done = 0;
        int          g;
        bit          exp_ov;
        do_reset();
        v[0] = 0; v[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!v[r] && $urandom_range(0, 2) == 0) begin
                    v[r] = 1;
                    d[r] = $urandom;
                    s[r] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
                    o[r] = 2'($urandom_range(0, 3));
                end
            end
            req0_valid = v[0]; req0_data = d[0]; req0_shamt = 5'(s[0]); req0_op = o[0];
            req1_valid = v[1]; req1_data = d[1]; req1_shamt = 5'(s[1]); req1_op = o[1];
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (m_idle) begin
                if (v[0] && v[1]) g = m_ptr;
                else if (v[0]) g = 0;
                else if (v[1]) g = 1;
            end
            exp_ov = !m_idle && cyc >= m_done;
            checks++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                errors++;
                $display("FAIL rand_ready@%0d: r0=%b r1=%b want grant %0d", cyc, req0_ready, req1_ready, g);
            end
            checks++;
            if (out_valid !== exp_ov || busy !== !m_idle) begin
                errors++;
                $display("FAIL rand_status@%0d: ov=%b busy=%b want %b %b", cyc, out_valid, busy, exp_ov, !m_idle);
            end
            if (exp_ov) begin
                checks++;
                if (out_data !== m_exp || out_id !== m_id) begin
                    errors++;
                    $display("FAIL rand_data@%0d: data=%h id=%b want %h %b", cyc, out_data, out_id, m_exp, m_id);
                end
            end
            if (g >= 0) begin
                m_idle = 0;
                m_id   = g[0];
                m_exp  = ref_shift(d[g], s[g], o[g]);
                m_done = cyc + ref_lat(s[g], o[g]);
                v[g]   = 0;
            end else if (exp_ov && out_ready) begin
                m_idle = 1;
                m_ptr  = !m_id;
            end
            @(posedge clk);
            #0;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_sra();
        test_sll_srl();
        test_alternate();
        test_pass();
        test_hold();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_scheduler.md
SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

Interface
REQ-001 Parameter: WIDTH, 32, datapath width in bits.
REQ-002 Parameter: SHW, 5, shift-amount width; SHW SHALL equal log2(WIDTH).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 req0_valid  in  1  requester 0 has a shift request.
REQ-006 req0_ready  out  1  requester 0 request accepted this cycle.
REQ-007 req0_data  in  WIDTH  operand of requester 0.
REQ-008 req0_shamt  in  SHW  shift amount of requester 0.
REQ-009 req0_op  in  2  op of requester 0: 00 SLL, 01 SRL, 10 SRA, 11 PASS.
REQ-010 req1_valid, req1_ready, req1_data, req1_shamt, req1_op  as REQ-005..009, for requester 1.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer takes result.
REQ-013 out_data  out  WIDTH  shift result.
REQ-014 out_id  out  1  index of requester that owns out_data.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-017 IDLE: if any reqN_valid, grant one requester; reqN_ready SHALL be high combinationally for the granted requester only, in that cycle only.
REQ-018 Arbitration SHALL be round-robin; the priority pointer SHALL favor req0 after reset.
REQ-019 Both valid in IDLE: pointer holder SHALL be granted; the other SHALL see ready low.
REQ-020 On grant, data, shamt, op and id SHALL be captured; the remaining count SHALL load shamt.
REQ-021 Grant with shamt==0 or op==11: next state DONE, result = captured data unchanged.
REQ-022 Otherwise: next state SHIFT.
REQ-023 SHIFT: each cycle SHALL shift the working register by exactly 1 bit and decrement the count.
REQ-024 SHIFT: when count==1, the final shift SHALL occur and next state SHALL be DONE.
REQ-025 SLL: zero-fill at LSB.
REQ-026 SRL: zero-fill at MSB.
REQ-027 SRA: MSB of the working register replicated into MSB, giving the arithmetic right shift by shamt.
REQ-028 Latency: request accepted at cycle T SHALL give out_valid high from cycle T+1+shamt; PASS and shamt==0 give T+1.
REQ-029 DONE: out_valid=1; out_data and out_id SHALL be held stable until out_ready.
REQ-030 out_valid && out_ready: next state IDLE; pointer SHALL move to the requester not just served.
REQ-031 No request SHALL be accepted outside IDLE.
REQ-032 The earliest next accept SHALL be the cycle after the out handshake; no bubble beyond that.
REQ-033 Requests not granted SHALL NOT be dropped by this block; requesters hold valid until ready.
REQ-034 out_valid SHALL be low in IDLE and SHIFT.
REQ-035 out_data SHALL change only on entry to DONE.

Reset
REQ-036 rst_n low at a clock edge SHALL force IDLE regardless of state, including mid-SHIFT or DONE; any in-flight result SHALL be discarded.
REQ-037 Reset values: out_valid 0, out_data 0, out_id 0, busy 0, req0_ready 0, req1_ready 0, count 0, pointer = req0.
REQ-038 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-039 req0 SRA data 0x80000000 shamt 31, out_ready=1 -> out_data 0xFFFFFFFF, out_id 0, out_valid at T+32.
REQ-040 req1 SLL 0x00000001 shamt 4, then SRL 0xF0000000 shamt 28 -> results 0x00000010 and 0x0000000F, latencies 5 and 29.
REQ-041 Both valid from reset, out_ready=1 -> grants alternate req0, req1, req0.
REQ-042 req0 op PASS 0x12345678 shamt 7 -> out_data 0x12345678 at T+1.
REQ-043 out_ready held low 10 cycles in DONE -> out_data, out_id stable, both readies low; one cycle after out_ready rises, the pending request is accepted.
REQ-044 rst_n low 1 cycle mid-SHIFT -> next cycle IDLE, out_valid 0, busy 0; the next grant goes to req0.
